// File: rtl/ama_riscv_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues requests to a variable-latency
// instruction memory, buffers up to two returned instructions and feeds the ID stage.
module ama_riscv_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP          = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  pc_sel,
    input  logic        pc_we,
    input  logic        stall_if,
    input  logic        clear_if,
    input  logic [31:0] alu_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        inst_valid_id
);

    typedef enum logic [1:0] {
        PC_INC  = 2'd0,
        PC_ALU  = 2'd1,
        PC_RST  = 2'd2,
        PC_HOLD = 2'd3
    } pc_sel_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    pc_sel_t      sel;
    logic [31:0]  pc_f;
    logic [1:0]   outst, drop, fifo_cnt;
    logic [1:0]   outst_nxt, drop_nxt, fifo_cnt_nxt;
    logic         fifo_rd, pcq_rd, pcq_wr;
    fetch_entry_t fifo_mem [2];
    logic [31:0]  pcq_mem [2];

    logic         redirect, hs, rsp, rsp_keep, id_free;
    logic         load_fifo, load_byp, push, pop, fifo_wr;
    logic [2:0]   occ;
    logic [31:0]  target;
    fetch_entry_t rsp_entry, fifo_head;

    assign sel      = pc_sel_t'(pc_sel);
    assign redirect = pc_we && (sel == PC_ALU || sel == PC_RST);
    assign target   = (sel == PC_RST) ? RESET_VECTOR : (alu_out & 32'hFFFF_FFFC);
    assign occ      = {1'b0, outst} + {1'b0, fifo_cnt};

    // Issue only while the buffer can absorb every answer already promised.
    assign imem_req  = rst && pc_we && (sel == PC_INC) && (occ < 3'd2);
    assign imem_addr = pc_f;
    assign hs        = imem_req && imem_ready;

    // Stray responses with nothing outstanding are ignored entirely.
    assign rsp       = imem_rvalid && (outst != 2'd0);
    assign rsp_keep  = rsp && (drop == 2'd0) && !redirect && !clear_if;
    assign rsp_entry = {imem_rdata, pcq_mem[pcq_rd]};
    assign fifo_head = fifo_mem[fifo_rd];
    assign fifo_wr   = fifo_rd ^ fifo_cnt[0];

    // An empty buffer forwards this cycle's response straight to ID (N+2 latency).
    assign id_free   = !clear_if && !stall_if && !redirect;
    assign load_fifo = id_free && (fifo_cnt != 2'd0);
    assign load_byp  = id_free && (fifo_cnt == 2'd0) && rsp_keep;
    assign push      = rsp_keep && !load_byp;
    assign pop       = load_fifo;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        outst_nxt    = outst;
        drop_nxt     = drop;
        fifo_cnt_nxt = fifo_cnt;
        if (hs && !rsp)
            outst_nxt = outst + 2'd1;
        else if (rsp && !hs)
            outst_nxt = outst - 2'd1;
        // After a redirect every request still in flight belongs to the old path.
        if (redirect)
            drop_nxt = outst_nxt;
        else if (rsp && drop != 2'd0)
            drop_nxt = drop - 2'd1;
        if (redirect || clear_if)
            fifo_cnt_nxt = 2'd0;
        else if (push && !pop)
            fifo_cnt_nxt = fifo_cnt + 2'd1;
        else if (pop && !push)
            fifo_cnt_nxt = fifo_cnt - 2'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_f          <= RESET_VECTOR;
            outst         <= 2'd0;
            drop          <= 2'd0;
            fifo_cnt      <= 2'd0;
            fifo_rd       <= 1'b0;
            pcq_rd        <= 1'b0;
            pcq_wr        <= 1'b0;
            inst_id       <= NOP;
            pc_id         <= 32'h0;
            inst_valid_id <= 1'b0;
        end else begin
            outst    <= outst_nxt;
            drop     <= drop_nxt;
            fifo_cnt <= fifo_cnt_nxt;
            if (redirect)
                pc_f <= target;
            else if (hs)
                pc_f <= pc_f + 32'd4;
            if (hs)
                pcq_wr <= ~pcq_wr;
            if (rsp)
                pcq_rd <= ~pcq_rd;
            if (pop)
                fifo_rd <= ~fifo_rd;

            if (clear_if) begin
                inst_id       <= NOP;
                inst_valid_id <= 1'b0;
            end else if (stall_if) begin
                // ID holds inst, pc and valid
            end else if (load_fifo) begin
                inst_id       <= fifo_head.inst;
                pc_id         <= fifo_head.pc;
                inst_valid_id <= 1'b1;
            end else if (load_byp) begin
                inst_id       <= rsp_entry.inst;
                pc_id         <= rsp_entry.pc;
                inst_valid_id <= 1'b1;
            end else begin
                inst_id       <= NOP;
                inst_valid_id <= 1'b0;
            end
        end
    end

    // NOTE: storage arrays carry no reset; the counters and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[fifo_wr] <= rsp_entry;
        if (hs)
            pcq_mem[pcq_wr] <= pc_f;
    end

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// Scoreboarded bench for ama_riscv_fetch: a queue-level fetch model predicts the ID
// stream and request behaviour against a randomized, variable-latency memory.
module tb_ama_riscv_fetch;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  pc_sel = 2'd0;
    logic        pc_we = 1'b0, stall_if = 1'b0, clear_if = 1'b0;
    logic [31:0] alu_out = 32'h0;
    logic        imem_req, imem_ready = 1'b1, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = 32'h0;
    logic [31:0] inst_id, pc_id;
    logic        inst_valid_id;

    ama_riscv_fetch #(.RESET_VECTOR(RV), .NOP(NOP)) dut (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .pc_we(pc_we), .stall_if(stall_if),
        .clear_if(clear_if), .alu_out(alu_out), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_id(inst_id), .pc_id(pc_id), .inst_valid_id(inst_valid_id)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit stale; } req_t;
    typedef struct packed { logic [31:0] inst; logic [31:0] pc; } ent_t;
    typedef struct packed { logic valid; logic [31:0] inst; logic [31:0] pc; } idexp_t;
    typedef struct { logic [31:0] addr; int due; } mem_t;

    int n_tests = 0, n_fail = 0;
    int cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
    logic [31:0] key = 32'h0;

    logic [31:0] m_pc_f, m_inst, m_pc;
    logic        m_valid;
    req_t        inflight[$];
    ent_t        returned[$];
    idexp_t      sb[$];
    mem_t        memq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ key;
    endfunction

    // Monitor: one expected ID-stage state per clock edge, compared mid-cycle.
    initial begin
        idexp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("id_valid", {31'b0, inst_valid_id}, {31'b0, e.valid});
                check("id_inst", inst_id, e.inst);
                check("id_pc", pc_id, e.pc);
            end
        end
    end

    function automatic void model_reset();
        m_pc_f = RV; m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0;
        inflight.delete(); returned.delete(); memq.delete(); sb.delete();
        last_due = cyc;
    endfunction

    // Assert reset 2 time units into a cycle; outputs must react with no clock edge.
    task automatic do_reset();
        #2;
        pc_we = 1'b1; pc_sel = 2'd0; stall_if = 1'b0; clear_if = 1'b0;
        imem_rvalid = 1'b0; imem_ready = 1'b1;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_inst", inst_id, NOP);
        check("rst_pc", pc_id, 32'h0);
        check("rst_valid", {31'b0, inst_valid_id}, 32'h0);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, RV);
        @(posedge clk); @(posedge clk); cyc += 2; #1;
        rst = 1'b1;
    endtask

    // One cycle: drive at edge+1, check combinational request at edge+2, step the model.
    task automatic run_cycle(input logic we, input logic [1:0] sel, input logic st,
                             input logic cl, input logic [31:0] alu, input logic rdy);
        logic exp_req, hs, redir, rv;
        int due;
        req_t r;
        ent_t en;
        pc_we = we; pc_sel = sel; stall_if = st; clear_if = cl; alu_out = alu; imem_ready = rdy;
        rv = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_data(memq[0].addr) : $urandom;
        #1;
        exp_req = we && (sel == 2'd0) && (inflight.size() + returned.size() < 2);
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        check("imem_addr", imem_addr, m_pc_f);
        hs    = exp_req && rdy;
        redir = we && (sel == 2'd1 || sel == 2'd2);

        if (rv) begin
            assert (inflight.size() > 0) else $error("response with nothing outstanding");
            r = inflight.pop_front();
            void'(memq.pop_front());
            if (!r.stale && !redir && !cl)
                returned.push_back({mem_data(r.pc), r.pc});
        end
        if (cl) begin
            m_inst = NOP; m_valid = 1'b0; returned.delete();
        end else if (st) begin
            if (redir) returned.delete();
        end else if (redir) begin
            returned.delete(); m_inst = NOP; m_valid = 1'b0;
        end else if (returned.size() > 0) begin
            en = returned.pop_front();
            m_inst = en.inst; m_pc = en.pc; m_valid = 1'b1;
        end else begin
            m_inst = NOP; m_valid = 1'b0;
        end
        if (redir) begin
            for (int i = 0; i < inflight.size(); i++) inflight[i].stale = 1'b1;
            m_pc_f = (sel == 2'd2) ? RV : (alu & 32'hFFFF_FFFC);
        end
        if (hs) begin
            inflight.push_back('{pc: m_pc_f, stale: 1'b0});
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: m_pc_f, due: due});
            m_pc_f = m_pc_f + 32'd4;
        end
        @(posedge clk);
        sb.push_back({m_valid, m_inst, m_pc});
        cyc++;
        #1;
    endtask

    initial begin
        bit done;
        logic [1:0] s;
        int p;
        @(posedge clk); #1;

        // Sequential fetch, 1-cycle memory returning the address as data.
        key = 32'h0; lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 20; i++) run_cycle(1, 0, 0, 0, 0, 1);

        // Redirect to 0x100 while two requests are in flight on a 3-cycle memory.
        key = 32'hC0DE_0000; lat_min = 3; lat_max = 3;
        do_reset();
        done = 0;
        for (int i = 0; i < 30; i++) begin
            if (!done && inflight.size() == 2) begin
                done = 1;
                run_cycle(1, 1, 0, 0, 32'h0000_0103, 1);
            end else
                run_cycle(1, 0, 0, 0, 0, 1);
        end
        check("redirect_seen", {31'b0, done}, 32'h1);

        // Stall for 4 cycles, then clear together with stall, then memory not ready.
        lat_min = 1; lat_max = 1;
        do_reset();
        for (int i = 0; i < 30; i++)
            run_cycle(1, 0, (i >= 6 && i < 10) || i == 15, i == 15, 0, !(i >= 20 && i < 25));

        // Randomized traffic with an asynchronous reset in the middle.
        key = $urandom; lat_min = 1; lat_max = 3;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i == 400) begin
                do_reset();
                key = $urandom;
            end
            p = $urandom_range(99, 0);
            s = (p < 88) ? 2'd0 : (p < 94) ? 2'd1 : (p < 96) ? 2'd2 : 2'd3;
            run_cycle($urandom_range(9, 0) != 0, s, $urandom_range(99, 0) < 15,
                      $urandom_range(99, 0) < 4, $urandom, $urandom_range(99, 0) < 75);
        end
        run_cycle(0, 3, 0, 0, 0, 1);
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
